bcd_update_ctrl: RTL and testbench

//  Sequencer between the board switches and a multi-cycle BCD converter
//  (shift-add-3). Waits for the binary input to hold steady, issues one

---
 rtl/bcd_update_ctrl.sv | 175 +++++++++++++++++
 tb/tb_bcd_update_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_update_ctrl.sv
// ============================================================================
// Module   : bcd_update_ctrl
// Purpose  : Debounces the switch value. It issues one start pulse to a
//            multi-cycle binary-to-BCD converter, waits for done with a
//            timeout, and latches the resulting digits for display.
// Options  : define BCD_UPD_LZ_BLANK_EN to add the o_blank leading-zero mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_update_ctrl #(
  parameter int P_BIN_W       = 9,
  parameter int P_DIGITS      = 4,
  parameter int P_STABLE_CYC  = 500000,
  parameter int P_TIMEOUT_CYC = 64
) (
  input  logic                    i_clock_50mhz,
  input  logic                    i_reset,
  input  logic [P_BIN_W-1:0]      i_bin_val,
  output logic                    o_conv_start,
  output logic [P_BIN_W-1:0]      o_conv_bin,
  input  logic                    i_conv_done,
  input  logic [4*P_DIGITS-1:0]   i_conv_bcd,
  output logic [4*P_DIGITS-1:0]   o_bcd,
  output logic                    o_bcd_valid,
  output logic                    o_busy,
  output logic                    o_err
`ifdef BCD_UPD_LZ_BLANK_EN
  ,
  output logic [P_DIGITS-1:0]     o_blank
`endif
);

  localparam int STAB_W = (P_STABLE_CYC > 1) ? $clog2(P_STABLE_CYC) : 1;
  localparam int TO_W   = (P_TIMEOUT_CYC > 1) ? $clog2(P_TIMEOUT_CYC) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(P_STABLE_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(P_TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_START  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [P_BIN_W-1:0]    sync_meta_q, sync_q;
  logic [P_BIN_W-1:0]    cand_q, cand_d;
  logic [P_BIN_W-1:0]    last_q, last_d;
  logic                  first_q, first_d;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [4*P_DIGITS-1:0] bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
`ifdef BCD_UPD_LZ_BLANK_EN
  logic [P_DIGITS-1:0]   blank_q, blank_d;
  logic [P_DIGITS-1:0]   w_blank;
  logic                  w_all_zero;

  // Scan from the top digit down; digit 0 is always shown.
  always_comb begin
    w_all_zero = 1'b1;
    w_blank    = '0;
    for (int i = P_DIGITS - 1; i > 0; i--) begin
      w_all_zero = w_all_zero && (i_conv_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = w_all_zero;
    end
  end
`endif

  always_ff @(posedge i_clock_50mhz) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      sync_meta_q <= '0;
      sync_q      <= '0;
      cand_q      <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      stab_cnt_q  <= '0;
      to_cnt_q    <= '0;
      bcd_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef BCD_UPD_LZ_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync_meta_q <= i_bin_val;
      sync_q      <= sync_meta_q;
      cand_q      <= cand_d;
      last_q      <= last_d;
      first_q     <= first_d;
      stab_cnt_q  <= stab_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
`ifdef BCD_UPD_LZ_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    last_d     = last_q;
    first_d    = first_q;
    stab_cnt_d = stab_cnt_q;
    to_cnt_d   = to_cnt_q;
    bcd_d      = bcd_q;
    valid_d    = valid_q;
    err_d      = err_q;
`ifdef BCD_UPD_LZ_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if ((sync_q != last_q) || first_q) begin
          cand_d     = sync_q;
          stab_cnt_d = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sync_q != cand_q) begin
          cand_d     = sync_q;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = S_START;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final timeout cycle still counts as success.
        if (i_conv_done) begin
          bcd_d   = i_conv_bcd;
          valid_d = 1'b1;
          last_d  = cand_q;
          first_d = 1'b0;
`ifdef BCD_UPD_LZ_BLANK_EN
          blank_d = w_blank;
`endif
          state_d = S_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_conv_start = (state_q == S_START) && !i_reset;
    o_conv_bin   = ((state_q == S_START) || (state_q == S_WAIT)) ? cand_q : '0;
    o_busy       = (state_q != S_IDLE);
    o_bcd        = bcd_q;
    o_bcd_valid  = valid_q;
    o_err        = err_q;
`ifdef BCD_UPD_LZ_BLANK_EN
    o_blank      = blank_q;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_update_ctrl.sv
// ============================================================================
// Module   : tb_bcd_update_ctrl
// Purpose  : Directed bench for bcd_update_ctrl with a behavioural converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_update_ctrl;

  localparam int C_BIN_W   = 9;
  localparam int C_DIGITS  = 4;
  localparam int C_STABLE  = 4;
  localparam int C_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  bin_val;
  logic        conv_start;
  logic [8:0]  conv_bin;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        err;
`ifdef BCD_UPD_LZ_BLANK_EN
  logic [3:0]  blank;
`endif

  always #5 clk = ~clk;

  bcd_update_ctrl #(
    .P_BIN_W      (C_BIN_W),
    .P_DIGITS     (C_DIGITS),
    .P_STABLE_CYC (C_STABLE),
    .P_TIMEOUT_CYC(C_TIMEOUT)
  ) u_dut (
    .i_clock_50mhz(clk),
    .i_reset      (rst),
    .i_bin_val    (bin_val),
    .o_conv_start (conv_start),
    .o_conv_bin   (conv_bin),
    .i_conv_done  (conv_done),
    .i_conv_bcd   (conv_bcd),
    .o_bcd        (bcd),
    .o_bcd_valid  (bcd_valid),
    .o_busy       (busy),
    .o_err        (err)
`ifdef BCD_UPD_LZ_BLANK_EN
    ,
    .o_blank      (blank)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: answers lat cycles after the start pulse when enabled.
  // lat must stay within the timeout window for a normal conversion.
  int         lat = 5;
  bit         conv_en = 1'b1;
  int         stray_req = 0;
  int         stray_ack = 0;
  int         cd = 0;
  int         n_starts = 0;
  logic [8:0] pend_bin = '0;

  function automatic logic [15:0] to_bcd(input logic [8:0] v);
    int x;
    x = int'(v);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  initial begin
    conv_done = 1'b0;
    conv_bcd  = 16'hBEEF;
  end

  always @(negedge clk) begin
    conv_done = 1'b0;
    conv_bcd  = 16'hBEEF;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        conv_done = 1'b1;
        conv_bcd  = to_bcd(pend_bin);
      end
    end
    if (stray_req != stray_ack) begin
      conv_done = 1'b1;
      conv_bcd  = 16'h9999;
      stray_ack = stray_req;
    end
    if (conv_start) begin
      n_starts++;
      if (conv_en) begin
        cd       = lat;
        pend_bin = conv_bin;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int s_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, input int t0, input int exp_lat,
                            input logic [8:0] exp_bin);
    int n;
    n = 0;
    while (!conv_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    s_cyc = cyc;
    check_eq({tag, "_seen"}, 32'(conv_start), 32'd1);
    check_eq({tag, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    check_eq({tag, "_bin"}, 32'(conv_bin), 32'(exp_bin));
  endtask

  int t0;
  int base;

  initial begin
    rst     = 1'b1;
    bin_val = 9'd0;
    step(3);

    // 1: reset state, then the first conversion of value 0
    check_eq("rst_bcd", 32'(bcd), 32'h0);
    check_eq("rst_valid", 32'(bcd_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_start", 32'(conv_start), 32'd0);
`ifdef BCD_UPD_LZ_BLANK_EN
    check_eq("rst_blank", 32'(blank), 32'h0);
`endif
    rst  = 1'b0;
    t0   = cyc;
    base = n_starts;
    wait_start("t1_start", t0, 5, 9'd0);
    step(5);
    check_eq("t1_valid_early", 32'(bcd_valid), 32'd0);
    step(1);
    check_eq("t1_valid", 32'(bcd_valid), 32'd1);
    check_eq("t1_bcd", 32'(bcd), 32'h0000);
    check_eq("t1_busy", 32'(busy), 32'd0);
`ifdef BCD_UPD_LZ_BLANK_EN
    check_eq("t1_blank", 32'(blank), 32'hE);
`endif
    step(10);
    check_eq("t1_one_start", 32'(n_starts - base), 32'd1);

    // 2: 0 -> 345
    bin_val = 9'd345;
    t0      = cyc;
    base    = n_starts;
    wait_start("t2_start", t0, 7, 9'd345);
    check_eq("t2_busy", 32'(busy), 32'd1);
    step(5);
    check_eq("t2_bcd_hold", 32'(bcd), 32'h0000);
    step(1);
    check_eq("t2_bcd", 32'(bcd), 32'h0345);
    step(10);
    check_eq("t2_one_start", 32'(n_starts - base), 32'd1);

    // 3: toggling 123/124 must not start until 124 holds
    base = n_starts;
    for (int k = 0; k < 6; k++) begin
      bin_val = (k % 2 == 0) ? 9'd123 : 9'd124;
      t0      = cyc;
      step(2);
    end
    wait_start("t3_start", t0, 7, 9'd124);
    step(6);
    check_eq("t3_bcd", 32'(bcd), 32'h0124);
    check_eq("t3_one_start", 32'(n_starts - base), 32'd1);

    // done on the last timeout cycle wins
    lat     = 8;
    bin_val = 9'd200;
    t0      = cyc;
    base    = n_starts;
    wait_start("tb_start", t0, 7, 9'd200);
    step(8);
    check_eq("tb_bcd_hold", 32'(bcd), 32'h0124);
    check_eq("tb_busy_last", 32'(busy), 32'd1);
    step(1);
    check_eq("tb_bcd", 32'(bcd), 32'h0200);
    check_eq("tb_err", 32'(err), 32'd0);
    step(10);
    check_eq("tb_no_retry", 32'(n_starts - base), 32'd1);
    check_eq("tb_err_late", 32'(err), 32'd0);
    lat = 5;

    // 4: converter silent -> timeout, sticky error, automatic retry
    conv_en = 1'b0;
    bin_val = 9'd77;
    t0      = cyc;
    wait_start("t4_start", t0, 7, 9'd77);
    t0 = s_cyc;
    step(8);
    check_eq("t4_err_early", 32'(err), 32'd0);
    check_eq("t4_busy_wait", 32'(busy), 32'd1);
    step(1);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_busy_idle", 32'(busy), 32'd0);
    check_eq("t4_bcd_keep", 32'(bcd), 32'h0200);
    conv_en = 1'b1;
    wait_start("t4_retry", t0, 14, 9'd77);
    step(6);
    check_eq("t4_bcd", 32'(bcd), 32'h0077);
    check_eq("t4_err_sticky", 32'(err), 32'd1);

    // 5: input change during WAIT is picked up after the latch
    bin_val = 9'd345;
    t0      = cyc;
    wait_start("t5_start", t0, 7, 9'd345);
    t0 = s_cyc;
    step(2);
    bin_val = 9'd500;
    step(1);
    check_eq("t5_bin_held", 32'(conv_bin), 32'd345);
    step(3);
    check_eq("t5_bcd", 32'(bcd), 32'h0345);
    wait_start("t5_second", t0, 11, 9'd500);
    step(6);
    check_eq("t5_bcd2", 32'(bcd), 32'h0500);
    base = n_starts;
    stray_req++;
    step(4);
    check_eq("t5_stray_bcd", 32'(bcd), 32'h0500);
    check_eq("t5_stray_busy", 32'(busy), 32'd0);
    check_eq("t5_stray_start", 32'(n_starts - base), 32'd0);

    // 6: reset mid-WAIT
    bin_val = 9'd45;
    t0      = cyc;
    wait_start("t6_start", t0, 7, 9'd45);
    step(2);
    rst = 1'b1;
    step(1);
    check_eq("t6_bcd", 32'(bcd), 32'h0);
    check_eq("t6_valid", 32'(bcd_valid), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_err", 32'(err), 32'd0);
    check_eq("t6_start", 32'(conv_start), 32'd0);
`ifdef BCD_UPD_LZ_BLANK_EN
    check_eq("t6_blank_rst", 32'(blank), 32'h0);
`endif
    rst = 1'b0;
    t0  = cyc;
    wait_start("t6_restart", t0, 7, 9'd45);
    step(6);
    check_eq("t6_bcd2", 32'(bcd), 32'h0045);
    check_eq("t6_valid2", 32'(bcd_valid), 32'd1);
`ifdef BCD_UPD_LZ_BLANK_EN
    check_eq("t6_blank", 32'(blank), 32'hC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
